// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: stage state encoding, NOP payload, stage widths.
package pipe_stage_reg_pkg;

  // Payload widths of the classic five-stage boundaries.
  localparam int unsigned IF_ID_W  = 64;
  localparam int unsigned ID_EX_W  = 160;
  localparam int unsigned EX_MEM_W = 112;
  localparam int unsigned MEM_WB_W = 72;

  // All-zero payload doubles as the NOP that fills empty slots.
  localparam logic [IF_ID_W-1:0] NOP_BUBBLE = '0;

  // Width of the occupancy report (0..2 entries).
  localparam int unsigned OCC_W = 2;

  // Entry-count state of an elastic stage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // IF/ID payload layout.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_payload_t;

  // Number of entries held in a given state.
  function automatic logic [OCC_W-1:0] state_occupancy(input stage_state_e s);
    logic [OCC_W-1:0] occ;
    occ = OCC_W'(0);
    case (s)
      EMPTY:   occ = OCC_W'(0);
      HALF:    occ = OCC_W'(1);
      FULL:    occ = OCC_W'(2);
      default: occ = OCC_W'(0);
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle on both sides of a pipeline stage register.
interface pipe_stage_reg_if #(
  parameter int unsigned WIDTH = 64
) ();

  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] in_data_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] out_data_o;

  // Stage-side view: consumes upstream payload, produces downstream payload.
  modport slave (
    input  in_valid_i,
    input  in_data_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output out_data_o
  );

  // Environment-side view: drives upstream payload and downstream ready.
  modport master (
    output in_valid_i,
    output in_data_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  out_data_o
  );

endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// CNT_W-bit saturating accumulator with a 0..2 increment per enabled cycle.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [1:0]       inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   sum_c;

  // One spare bit catches the carry; any carry means the count is pinned at max.
  always_comb begin
    sum_c = {1'b0, cnt_q} + (CNT_W+1)'(inc_i);
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = sum_c[CNT_W] ? {CNT_W{1'b1}} : sum_c[CNT_W-1:0];
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready payload with freeze, flush
// (bubble insertion), optional skid entry and a squash counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned      WIDTH  = 64,
  parameter int unsigned      SKID   = 1,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter int unsigned      CNT_W  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 freeze_i,
  input  logic                 flush_i,
  pipe_stage_reg_if.slave      bus,
  output logic [OCC_W-1:0]     occupancy_o,
  output logic [CNT_W-1:0]     squash_cnt_o
);

  stage_state_e     state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  logic             in_ready;
  logic             in_fire;
  logic             out_fire;
  logic             held_valid;

  assign held_valid = (state_q != EMPTY);

  // Ready and fire terms; with a skid entry, ready depends only on our own state.
  always_comb begin
    in_ready = 1'b0;
    if (!freeze_i) begin
      if (SKID != 0) begin
        in_ready = (state_q != FULL);
      end else begin
        in_ready = (state_q == EMPTY) || bus.out_ready_i;
      end
    end
    in_fire  = bus.in_valid_i & in_ready & ~flush_i;
    out_fire = held_valid & bus.out_ready_i & ~freeze_i & ~flush_i;
  end

  // Entry FSM and payload registers; empty slots always hold BUBBLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else if (freeze_i) begin
      state_q <= state_q;
      main_q  <= main_q;
      skid_q  <= skid_q;
    end else if (flush_i) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_q <= HALF;
            main_q  <= bus.in_data_i;
          end
        end
        HALF: begin
          if (in_fire && out_fire) begin
            main_q <= bus.in_data_i;
          end else if (in_fire && (SKID != 0)) begin
            state_q <= FULL;
            skid_q  <= bus.in_data_i;
          end else if (out_fire) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_q <= HALF;
            main_q  <= skid_q;
            skid_q  <= BUBBLE;
          end
        end
        default: begin
          state_q <= EMPTY;
          main_q  <= BUBBLE;
          skid_q  <= BUBBLE;
        end
      endcase
    end
  end

  // Outputs come straight from the state and payload registers.
  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = held_valid;
  assign bus.out_data_o  = main_q;
  assign occupancy_o     = state_occupancy(state_q);

  // Entries killed by a flush; frozen cycles never count.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_squash_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (flush_i & ~freeze_i),
    .inc_i (occupancy_o),
    .cnt_o (squash_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: SKID=1/CNT_W=16 instance (a) and SKID=0/CNT_W=2 instance (b).
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam int unsigned W = 16;
  localparam logic [W-1:0] BUB_A = 16'h00EE;
  localparam logic [W-1:0] BUB_B = 16'h0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       frz_a, fl_a, frz_b, fl_b;
  logic [1:0] occ_a, occ_b;
  logic [15:0] sq_a;
  logic [1:0]  sq_b;

  int n_assert = 0;
  int n_fail   = 0;

  pipe_stage_reg_if #(.WIDTH(W)) ifa ();
  pipe_stage_reg_if #(.WIDTH(W)) ifb ();

  pipe_stage_reg #(.WIDTH(W), .SKID(1), .BUBBLE(BUB_A), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .freeze_i(frz_a), .flush_i(fl_a),
    .bus(ifa), .occupancy_o(occ_a), .squash_cnt_o(sq_a)
  );

  pipe_stage_reg #(.WIDTH(W), .SKID(0), .BUBBLE(BUB_B), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .freeze_i(frz_b), .flush_i(fl_b),
    .bus(ifb), .occupancy_o(occ_b), .squash_cnt_o(sq_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [15:0] d, input logic [1:0] o);
    chk({tag, "_valid"}, 32'(ifa.out_valid_o), 32'(v));
    chk({tag, "_data"},  32'(ifa.out_data_o),  32'(d));
    chk({tag, "_occ"},   32'(occ_a),           32'(o));
  endtask

  task automatic chk_b(input string tag, input logic v, input logic [15:0] d, input logic [1:0] o);
    chk({tag, "_valid"}, 32'(ifb.out_valid_o), 32'(v));
    chk({tag, "_data"},  32'(ifb.out_data_o),  32'(d));
    chk({tag, "_occ"},   32'(occ_b),           32'(o));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    frz_a = 1'b0; fl_a = 1'b0; frz_b = 1'b0; fl_b = 1'b0;
    ifa.in_valid_i = 1'b1; ifa.in_data_i = 16'h0055; ifa.out_ready_i = 1'b1;
    ifb.in_valid_i = 1'b1; ifb.in_data_i = 16'h0066; ifb.out_ready_i = 1'b1;

    // Reset held two cycles with traffic offered.
    tick(); tick();
    chk_a("reset_a", 1'b0, BUB_A, 2'd0);
    chk("reset_sq_a", 32'(sq_a), 32'd0);
    chk_b("reset_b", 1'b0, BUB_B, 2'd0);
    chk("reset_sq_b", 32'(sq_b), 32'd0);

    // First payload after release appears one cycle later.
    rst = 1'b0;
    ifb.in_valid_i = 1'b0;
    ifa.in_data_i = 16'h0077;
    tick();
    chk_a("first_in", 1'b1, 16'h0077, 2'd1);
    ifa.in_valid_i = 1'b0;
    tick();
    chk_a("drain0", 1'b0, BUB_A, 2'd0);

    // Back-to-back streaming 0x1..0xA.
    for (int i = 1; i <= 10; i++) begin
      ifa.in_valid_i = 1'b1;
      ifa.in_data_i  = 16'(i);
      tick();
      chk_a("stream", 1'b1, 16'(i), 2'd1);
    end
    ifa.in_valid_i = 1'b0;
    tick();
    chk_a("drain1", 1'b0, BUB_A, 2'd0);

    // Backpressure with skid: 0xA, 0xB fill, 0xC waits upstream.
    ifa.out_ready_i = 1'b0;
    ifa.in_valid_i  = 1'b1;
    ifa.in_data_i   = 16'h000A;
    tick();
    chk_a("bp_a", 1'b1, 16'h000A, 2'd1);
    chk("bp_a_rdy", 32'(ifa.in_ready_o), 32'd1);
    ifa.in_data_i = 16'h000B;
    tick();
    chk_a("bp_b", 1'b1, 16'h000A, 2'd2);
    chk("bp_b_rdy", 32'(ifa.in_ready_o), 32'd0);
    ifa.in_data_i = 16'h000C;
    tick();
    chk_a("bp_c", 1'b1, 16'h000A, 2'd2);
    chk("bp_c_rdy", 32'(ifa.in_ready_o), 32'd0);
    ifa.out_ready_i = 1'b1;
    tick();
    chk_a("bp_out_b", 1'b1, 16'h000B, 2'd1);
    tick();
    chk_a("bp_out_c", 1'b1, 16'h000C, 2'd1);
    ifa.in_valid_i = 1'b0;
    tick();
    chk_a("bp_drain", 1'b0, BUB_A, 2'd0);

    // Fill to two entries for the freeze and flush steps.
    ifa.out_ready_i = 1'b0;
    ifa.in_valid_i  = 1'b1;
    ifa.in_data_i   = 16'h0001;
    tick();
    ifa.in_data_i = 16'h0002;
    tick();
    chk_a("fill2", 1'b1, 16'h0001, 2'd2);
    ifa.in_valid_i = 1'b0;

    // Freeze dominates flush and downstream ready.
    frz_a = 1'b1; fl_a = 1'b1; ifa.out_ready_i = 1'b1;
    #1;
    chk("frz_rdy0", 32'(ifa.in_ready_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("freeze", 1'b1, 16'h0001, 2'd2);
      chk("freeze_sq", 32'(sq_a), 32'd0);
      chk("freeze_rdy", 32'(ifa.in_ready_o), 32'd0);
    end

    // Flush at two entries with 0xD offered.
    frz_a = 1'b0;
    ifa.in_valid_i = 1'b1;
    ifa.in_data_i  = 16'h000D;
    tick();
    chk_a("flush", 1'b0, BUB_A, 2'd0);
    chk("flush_sq", 32'(sq_a), 32'd2);
    fl_a = 1'b0;
    ifa.in_valid_i = 1'b0;
    tick();
    chk_a("post_flush", 1'b0, BUB_A, 2'd0);
    chk("post_flush_sq", 32'(sq_a), 32'd2);

    // SKID=0 ready tracking and CNT_W=2 saturation.
    for (int k = 1; k <= 4; k++) begin
      ifb.out_ready_i = 1'b0;
      ifb.in_valid_i  = 1'b1;
      ifb.in_data_i   = 16'(k);
      tick();
      chk_b("b_fill", 1'b1, 16'(k), 2'd1);
      #1;
      chk("b_rdy_lo", 32'(ifb.in_ready_o), 32'd0);
      ifb.out_ready_i = 1'b1;
      #1;
      chk("b_rdy_hi", 32'(ifb.in_ready_o), 32'd1);
      ifb.out_ready_i = 1'b0;
      fl_b = 1'b1;
      ifb.in_data_i = 16'h0099;
      tick();
      chk_b("b_flush", 1'b0, BUB_B, 2'd0);
      chk("b_sq", 32'(sq_b), (k < 3) ? 32'(k) : 32'd3);
      fl_b = 1'b0;
      ifb.in_valid_i = 1'b0;
    end
    tick();
    chk_b("b_dropped", 1'b0, BUB_B, 2'd0);
    chk("b_empty_rdy", 32'(ifb.in_ready_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed IF/ID register; one generic pipeline stage register for any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a WIDTH-bit payload with a valid/ready handshake. Supports a global freeze (memory stall), flush with bubble insertion, and an optional skid entry that removes the combinational ready path.
- Counts squashed entries for performance analysis.

Parameters:
- WIDTH, 64, payload width in bits (for example, pc+instr for IF/ID).
- SKID, 1, 1 = two-entry elastic stage with registered in_ready_o; 0 = single entry with pass-through ready.
- BUBBLE, {WIDTH{1'b0}}, value driven on out_data_o whenever no valid entry is held (NOP encoding).
- CNT_W, 16, width of the squash counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- freeze_i  input  1  global memory stall; holds all state, no transfers.
- flush_i  input  1  squash all held entries and the incoming entry.
- in_valid_i  input  1  upstream has a payload.
- in_ready_o  output  1  stage accepts a payload this cycle.
- in_data_i  input  WIDTH  upstream payload.
- out_valid_o  output  1  registered; stage holds a valid payload.
- out_ready_i  input  1  downstream accepts this cycle.
- out_data_o  output  WIDTH  registered; head payload, or BUBBLE when empty.
- occupancy_o  output  2  number of held entries, 0..2.
- squash_cnt_o  output  CNT_W  saturating count of entries killed by flush.

Behaviour:
- Priority each cycle: rst_i > freeze_i > flush_i > normal operation.
- Reset (rst_i=1 at the edge):
  - state=EMPTY; out_valid_o=0; out_data_o=BUBBLE; skid entry cleared to BUBBLE.
  - occupancy_o=0; squash_cnt_o=0.
  - Reset in the middle of a transfer discards everything with no partial update.
- Firing conditions:
  - in_fire = in_valid_i & in_ready_o & ~flush_i.
  - out_fire = out_valid_o & out_ready_i & ~freeze_i & ~flush_i.
- in_ready_o:
  - Forced 0 while freeze_i=1.
  - SKID=1: 1 iff state!=FULL (no path from out_ready_i).
  - SKID=0: 1 iff state==EMPTY or out_ready_i=1.
  - In a flush cycle in_ready_o may be 1; the payload is consumed from upstream and dropped.
- Freeze: every register holds, squash_cnt_o included; flush_i is ignored in freeze cycles.
- Flush (freeze_i=0):
  - Next state=EMPTY; out_valid_o=0; out_data_o=BUBBLE.
  - squash_cnt_o += occupancy, saturating at 2^CNT_W-1.
  - The incoming payload is not counted.
- States: EMPTY (0 entries), HALF (main valid), FULL (main+skid valid; SKID=1 only). Transitions when no freeze/flush:
  - EMPTY: in_fire -> HALF, main<=in_data_i.
  - HALF, in_fire & out_fire -> HALF, main<=in_data_i.
  - HALF, in_fire & ~out_fire -> FULL, skid<=in_data_i (SKID=1). With SKID=0 this combination cannot occur.
  - HALF, ~in_fire & out_fire -> EMPTY, main<=BUBBLE.
  - HALF, neither -> hold.
  - FULL: in_fire impossible; out_fire -> HALF, main<=skid, skid<=BUBBLE; otherwise hold.
- Ordering: FIFO; latency is 1 cycle from in_fire to out_valid_o when the stage is empty; throughput is 1 per cycle.
- Outputs are stable while out_valid_o=1 and out_fire=0 (payload held under backpressure).
- occupancy_o is derived from state: EMPTY=0, HALF=1, FULL=2.
- Legacy IF/ID mapping:
  - IF_IDWrite=0 maps to out_ready_i=0 on the upstream side.
  - mem_stall maps to freeze_i.
  - flush maps to flush_i.

Decomposition:
- Shared pipeline package holds:
  - the state typedef {EMPTY, HALF, FULL};
  - the NOP/BUBBLE constant;
  - per-stage payload width constants (IF_ID_W=64, etc.).
- One natural sub-module, sat_counter (CNT_W-bit saturating adder with increment 0..2), instantiated for squash_cnt_o.
- The rest of the block is flat.

Test Plan:
- Reset: rst_i=1 for 2 cycles with in_valid_i=1 -> out_valid_o=0, out_data_o=BUBBLE, occupancy_o=0, squash_cnt_o=0. First valid input after release appears on out_data_o 1 cycle later.
- Streaming: 10 back-to-back payloads 0x1..0xA with out_ready_i=1 -> output 0x1..0xA in order, 1 per cycle, occupancy_o=1 throughout.
- Backpressure, SKID=1: out_ready_i=0 while sending 0xA, 0xB, 0xC -> occupancy_o reaches 2 and in_ready_o=0 with 0xC held upstream. On out_ready_i=1, the output order is 0xA, 0xB, 0xC and nothing is lost or duplicated.
- Freeze: freeze_i=1 for 3 cycles at occupancy 2 with flush_i=1 and out_ready_i=1 -> all outputs and squash_cnt_o are unchanged and in_ready_o=0.
- Flush: flush_i=1 at occupancy 2 with in_valid_i=1 (0xD) -> next cycle occupancy_o=0, out_data_o=BUBBLE, squash_cnt_o +=2, and 0xD never appears at the output.
- Saturation and SKID=0: with CNT_W=2, three flushes at occupancy 1 -> squash_cnt_o=3, then stays at 3 on a further flush. With SKID=0, in_ready_o follows out_ready_i in the same cycle while occupancy_o=1.
